soc_dma_master: RTL
===================

Name: soc_dma_master

Overview:
- Single-channel word-copy DMA engine. It acts as an initiator on the SoC memory bus, the opposite end from the peripheral slaves.
- It reads words from a source address and writes them to a destination address over a fixed-latency bus, with requests gated by an arbiter grant.
- Configuration arrives on plain ports from a control register block.
- Completion raises a one-cycle interrupt trigger that is routed into the SoC interrupt mapping.

Parameters:
- BUS_LATENCY, 1, cycles from a granted read request to valid bus_rdata (≥1).
- LEN_WIDTH, 16, width of the word-count and progress counters.

Ports:
- clk  input  1  system clock
- res_n  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse that launches a transfer
- src_addr  input  32  source byte address
- dst_addr  input  32  destination byte address
- word_count  input  LEN_WIDTH  number of 32-bit words to copy
- abort  input  1  level request to stop the transfer
- busy  output  1  transfer in progress
- error  output  1  sticky misalignment flag
- words_done  output  LEN_WIDTH  words written so far in the current or last transfer
- interrupt_trigger  output  1  one-cycle completion pulse
- bus_req  output  1  bus request
- bus_grant  input  1  arbiter grant, valid in any cycle where bus_req=1
- bus_addr  output  32  transaction address, word aligned
- bus_wr  output  1  1 = write, 0 = read
- bus_wdata  output  32  write data
- bus_wstrb  output  4  byte strobes
- bus_rdata  input  32  read data

Behaviour:
- Reset (res_n=0 sampled at a clk edge): state=IDLE. busy, error, interrupt_trigger, bus_req, bus_wr = 0. bus_addr, bus_wdata, words_done = 0. bus_wstrb = 0. Reset mid-transfer abandons the transfer with no pulse; bus_req is low the cycle after reset is sampled.
- Handshake:
  - A transaction occurs in a cycle where bus_req=1 and bus_grant=1.
  - While bus_req=1, bus_addr, bus_wr, bus_wdata and bus_wstrb hold stable until that grant cycle.
  - Reads: bus_rdata is valid exactly BUS_LATENCY cycles after the grant cycle.
  - Writes: no response.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
  - IDLE:
    - On start, latch the inputs. error is cleared at every accepted start.
    - If src_addr[1:0] or dst_addr[1:0] is nonzero: error=1, stay IDLE, no bus traffic, no pulse.
    - Else if word_count=0: go to DONE.
    - Else: go to RD_REQ and clear words_done.
    - start is ignored in every state other than IDLE.
  - RD_REQ: bus_req=1, bus_wr=0, bus_addr=cur_src, bus_wstrb=0. On grant, go to RD_WAIT with the wait counter set to BUS_LATENCY.
  - RD_WAIT:
    - bus_req=0. The counter decrements each cycle.
    - In the cycle where the counter equals 1 (grant cycle + BUS_LATENCY), capture bus_rdata into the data register and go to WR_REQ.
  - WR_REQ:
    - bus_req=1, bus_wr=1, bus_addr=cur_dst, bus_wdata=captured data, bus_wstrb=4'hF.
    - On grant: words_done+1; cur_src+4 and cur_dst+4, each modulo 2^32 (0xFFFFFFFC wraps to 0).
    - If this was the last word, go to DONE; else go to RD_REQ.
  - DONE: interrupt_trigger=1 for exactly this one cycle, busy=1, then go to IDLE.
- busy = 1 in every state other than IDLE.
- Throughput with continuous grant: BUS_LATENCY+2 cycles per word.
- Start timing: start sampled in cycle S gives RD_REQ in S+1.
- Abort:
  - In RD_REQ or WR_REQ, sampled in a cycle without grant: go to IDLE at the next edge. If grant and abort coincide, the granted transaction completes first, then the engine goes to IDLE.
  - In RD_WAIT: finish the wait, discard the data, then go to IDLE.
  - Aborts never produce a pulse. words_done keeps its value.
- Idle bus outputs: bus_req=0, bus_wstrb=0. bus_addr and bus_wdata hold their last values.

Test Plan:
- Copy 3 words, src=0x100, dst=0x200, BUS_LATENCY=1, bus_grant tied high:
  - Reads hit 0x100, 0x104, 0x108; writes hit 0x200, 0x204, 0x208 with the returned data and bus_wstrb=4'hF.
  - 3 cycles per word; interrupt_trigger pulses once in the cycle after the last write grant.
  - busy falls the cycle after the pulse; words_done=3.
- BUS_LATENCY=3, grant withheld for 4 cycles on each request:
  - Address, bus_wr and bus_wdata stay stable while waiting.
  - Data is captured exactly 3 cycles after the read grant; the copied data matches.
- word_count=0:
  - busy goes high one cycle later, with a pulse in that same cycle; busy falls next cycle.
  - bus_req is never asserted.
- src_addr=0x102:
  - error=1, busy stays 0, no bus_req, no pulse.
  - A following valid start clears error and copies correctly.
- Abort raised during RD_WAIT of word 2 of 5:
  - No write is issued for word 2; busy falls after the wait finishes.
  - words_done=1; no pulse.
  - A start pulse in the middle of a transfer is ignored.
- src=0xFFFFFFFC, 2 words:
  - Reads go to 0xFFFFFFFC then 0x00000000.
  - res_n asserted during the second WR_REQ forces all outputs to their reset values with no pulse.

Source files
------------

// File: rtl/soc_dma_master.sv
// Single-channel word-copy DMA initiator on a fixed-latency memory bus.
// Copies word_count words src->dst, one read then one write per word, and pulses on completion.
module soc_dma_master #(
   parameter int unsigned BUS_LATENCY = 1,
   parameter int unsigned LEN_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 res_n,
   input  logic                 start,
   input  logic [31:0]          src_addr,
   input  logic [31:0]          dst_addr,
   input  logic [LEN_WIDTH-1:0] word_count,
   input  logic                 abort,
   output logic                 busy,
   output logic                 error,
   output logic [LEN_WIDTH-1:0] words_done,
   output logic                 interrupt_trigger,
   output logic                 bus_req,
   input  logic                 bus_grant,
   output logic [31:0]          bus_addr,
   output logic                 bus_wr,
   output logic [31:0]          bus_wdata,
   output logic [3:0]           bus_wstrb,
   input  logic [31:0]          bus_rdata
);

   localparam int unsigned CntW = $clog2(BUS_LATENCY + 1);
   localparam logic [CntW-1:0] LatInit = CntW'(BUS_LATENCY);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StRdReq  = 3'd1;
   localparam logic [2:0] StRdWait = 3'd2;
   localparam logic [2:0] StWrReq  = 3'd3;
   localparam logic [2:0] StDone   = 3'd4;

   logic [2:0]           state_q, state_d;
   logic [31:0]          src_q, src_d;
   logic [31:0]          dst_q, dst_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [LEN_WIDTH-1:0] done_q, done_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 abort_pend_q, abort_pend_d;
   logic                 error_q, error_d;
   logic [31:0]          addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;

   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      dst_d        = dst_q;
      len_d        = len_q;
      done_d       = done_q;
      cnt_d        = cnt_q;
      abort_pend_d = abort_pend_q;
      error_d      = error_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               error_d      = 1'b0;
               abort_pend_d = 1'b0;
               if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
                  error_d = 1'b1;
               end else if (word_count == '0) begin
                  state_d = StDone;
               end else begin
                  state_d = StRdReq;
                  src_d   = src_addr;
                  dst_d   = dst_addr;
                  len_d   = word_count;
                  done_d  = '0;
                  addr_d  = src_addr;
               end
            end
         end
         StRdReq: begin
            if (bus_grant) begin
               state_d      = StRdWait;
               cnt_d        = LatInit;
               // A read granted together with abort still runs its wait out.
               abort_pend_d = abort;
            end else if (abort) begin
               state_d = StIdle;
            end
         end
         StRdWait: begin
            cnt_d = cnt_q - 1'b1;
            if (abort) begin
               abort_pend_d = 1'b1;
            end
            if (cnt_q == CntW'(1)) begin
               if (abort_pend_q || abort) begin
                  state_d = StIdle;
               end else begin
                  state_d = StWrReq;
                  wdata_d = bus_rdata;
                  addr_d  = dst_q;
               end
            end
         end
         StWrReq: begin
            if (bus_grant) begin
               done_d = done_q + 1'b1;
               src_d  = src_q + 32'd4;
               dst_d  = dst_q + 32'd4;
               if (abort) begin
                  state_d = StIdle;
               end else if (done_d == len_q) begin
                  state_d = StDone;
               end else begin
                  state_d = StRdReq;
                  addr_d  = src_q + 32'd4;
               end
            end else if (abort) begin
               state_d = StIdle;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!res_n) begin
         state_q      <= StIdle;
         src_q        <= '0;
         dst_q        <= '0;
         len_q        <= '0;
         done_q       <= '0;
         cnt_q        <= '0;
         abort_pend_q <= 1'b0;
         error_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         len_q        <= len_d;
         done_q       <= done_d;
         cnt_q        <= cnt_d;
         abort_pend_q <= abort_pend_d;
         error_q      <= error_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
      end
   end

   always_comb begin
      busy              = (state_q != StIdle);
      interrupt_trigger = (state_q == StDone);
      bus_req           = (state_q == StRdReq) || (state_q == StWrReq);
      bus_wr            = (state_q == StWrReq);
      bus_wstrb         = (state_q == StWrReq) ? 4'hF : 4'h0;
      bus_addr          = addr_q;
      bus_wdata         = wdata_q;
      error             = error_q;
      words_done        = done_q;
   end

endmodule
